// File: rtl/stage_id_pipe.sv
// Decode stage: register file with writeback bypass, immediate extension and an
// ID/EX output register with load-use stall, backpressure and flush handling.
module stage_id_pipe #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned NREGS  = 32,
   parameter int unsigned RA_W   = $clog2(NREGS),
   parameter int unsigned CTRL_W = 16,
   parameter int unsigned BYPASS = 1
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       instr_in,
   input  logic [DATA_W-1:0] npc_in,
   input  logic [CTRL_W-1:0] ctrl_in,
   input  logic [1:0]        ext_sel,
   input  logic              uses_rt,
   input  logic [RA_W-1:0]   dst_in,
   input  logic              mem_read_in,
   input  logic              flush,
   input  logic              wb_en,
   input  logic [RA_W-1:0]   wb_sel,
   input  logic [DATA_W-1:0] wb_dat,
   input  logic              wb_jal,
   input  logic [DATA_W-1:0] wb_npc,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] rdat1_out,
   output logic [DATA_W-1:0] rdat2_out,
   output logic [DATA_W-1:0] imm_out,
   output logic [DATA_W-1:0] npc_out,
   output logic [31:0]       instr_out,
   output logic [CTRL_W-1:0] ctrl_out,
   output logic [RA_W-1:0]   dst_out,
   output logic              mem_read_out
);

   localparam int unsigned INSTR_W = 32;
   localparam int unsigned IMM_W   = 16;
   localparam int unsigned FIELD_W = 5;

   typedef struct packed {
      logic [DATA_W-1:0]  rdat1;
      logic [DATA_W-1:0]  rdat2;
      logic [DATA_W-1:0]  imm;
      logic [DATA_W-1:0]  npc;
      logic [INSTR_W-1:0] instr;
      logic [CTRL_W-1:0]  ctrl;
      logic [RA_W-1:0]    dst;
      logic               mem_read;
   } idex_t;

   logic [DATA_W-1:0] regs [NREGS];
   logic [RA_W-1:0]   rs;
   logic [RA_W-1:0]   rt;
   logic [IMM_W-1:0]  imm;
   logic [DATA_W-1:0] wb_val;
   logic              wb_we;
   logic [DATA_W-1:0] rd1;
   logic [DATA_W-1:0] rd2;
   logic [DATA_W-1:0] imm_ext;
   logic              load_en;
   logic              hazard;
   idex_t             q;
   idex_t             d;
   logic              q_valid;

   // Source index fields, zero-padded or truncated to the register index width
   assign rs  = RA_W'(instr_in[25:21]);
   assign rt  = RA_W'(instr_in[20:16]);
   assign imm = instr_in[IMM_W-1:0];

   assign wb_val = wb_jal ? wb_npc : wb_dat;
   assign wb_we  = wb_en && (wb_sel != '0);

   // Architectural register file; entry 0 is never written
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         for (int i = 0; i < int'(NREGS); i++) begin
            regs[i] <= '0;
         end
      end else if (wb_we) begin
         regs[wb_sel] <= wb_val;
      end
   end

   // Operand read with optional same-cycle forwarding of the writeback value
   always_comb begin
      rd1 = regs[rs];
      rd2 = regs[rt];
      if (BYPASS != 0) begin
         if (wb_en && (wb_sel == rs)) rd1 = wb_val;
         if (wb_en && (wb_sel == rt)) rd2 = wb_val;
      end
      if (rs == '0) rd1 = '0;
      if (rt == '0) rd2 = '0;
   end

   // Immediate extension: sign, upper-half (lui) or zero
   always_comb begin
      imm_ext = DATA_W'(imm);
      case (ext_sel)
         2'd1:    imm_ext = {{(DATA_W - IMM_W){imm[IMM_W-1]}}, imm};
         2'd2:    imm_ext = DATA_W'({imm, {(INSTR_W - IMM_W){1'b0}}});
         default: imm_ext = DATA_W'(imm);
      endcase
   end

   // Load-use check against the load currently held in the output register
   assign load_en  = !q_valid || out_ready;
   assign hazard   = q_valid && q.mem_read && (q.dst != '0) &&
                     ((q.dst == rs) || (uses_rt && (q.dst == rt)));
   assign in_ready = load_en && (flush || !hazard);

   always_comb begin
      d          = q;
      d.rdat1    = rd1;
      d.rdat2    = rd2;
      d.imm      = imm_ext;
      d.npc      = npc_in;
      d.instr    = instr_in;
      d.ctrl     = ctrl_in;
      d.dst      = dst_in;
      d.mem_read = mem_read_in;
   end

   // ID/EX register; flush squashes even under backpressure, data is kept when invalid
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         q       <= '0;
         q_valid <= 1'b0;
      end else if (flush) begin
         q_valid <= 1'b0;
      end else if (load_en) begin
         if (hazard || !in_valid) begin
            q_valid <= 1'b0;
         end else begin
            q       <= d;
            q_valid <= 1'b1;
         end
      end
   end

   assign out_valid    = q_valid;
   assign rdat1_out    = q.rdat1;
   assign rdat2_out    = q.rdat2;
   assign imm_out      = q.imm;
   assign npc_out      = q.npc;
   assign instr_out    = q.instr;
   assign ctrl_out     = q.ctrl;
   assign dst_out      = q.dst;
   assign mem_read_out = q.mem_read;

   // Only FIELD_W index bits of the instruction are architecturally defined
   if (RA_W < 1 || FIELD_W < 1) begin : g_bad_param
      $error("stage_id_pipe: invalid index width");
   end

endmodule

// File: tb/tb_stage_id_pipe.sv
// Directed bench for stage_id_pipe: a reference model of the decode stage checked
// every cycle, plus literal expectations for the key scenarios.
module tb_stage_id_pipe;

   localparam int unsigned DW = 32;
   localparam int unsigned RW = 5;
   localparam int unsigned CW = 16;

   logic          CLK = 1'b0;
   logic          nRST;
   logic          in_valid, flush, uses_rt, mem_read_in, out_ready;
   logic          wb_en, wb_jal;
   logic [31:0]   instr_in;
   logic [DW-1:0] npc_in, wb_dat, wb_npc;
   logic [CW-1:0] ctrl_in;
   logic [1:0]    ext_sel;
   logic [RW-1:0] dst_in, wb_sel;

   logic          in_ready, out_valid, mem_read_out;
   logic [DW-1:0] rdat1_out, rdat2_out, imm_out, npc_out;
   logic [31:0]   instr_out;
   logic [CW-1:0] ctrl_out;
   logic [RW-1:0] dst_out;

   logic          nb_in_ready, nb_out_valid, nb_mem_read_out;
   logic [DW-1:0] nb_rdat1_out, nb_rdat2_out, nb_imm_out, nb_npc_out;
   logic [31:0]   nb_instr_out;
   logic [CW-1:0] nb_ctrl_out;
   logic [RW-1:0] nb_dst_out;

   int nvec  = 0;
   int nfail = 0;

   always #5 CLK = ~CLK;

   stage_id_pipe #(.DATA_W(DW), .NREGS(32), .CTRL_W(CW), .BYPASS(1)) dut (
      .CLK(CLK), .nRST(nRST), .in_valid(in_valid), .in_ready(in_ready),
      .instr_in(instr_in), .npc_in(npc_in), .ctrl_in(ctrl_in), .ext_sel(ext_sel),
      .uses_rt(uses_rt), .dst_in(dst_in), .mem_read_in(mem_read_in), .flush(flush),
      .wb_en(wb_en), .wb_sel(wb_sel), .wb_dat(wb_dat), .wb_jal(wb_jal), .wb_npc(wb_npc),
      .out_valid(out_valid), .out_ready(out_ready), .rdat1_out(rdat1_out),
      .rdat2_out(rdat2_out), .imm_out(imm_out), .npc_out(npc_out),
      .instr_out(instr_out), .ctrl_out(ctrl_out), .dst_out(dst_out),
      .mem_read_out(mem_read_out)
   );

   stage_id_pipe #(.DATA_W(DW), .NREGS(32), .CTRL_W(CW), .BYPASS(0)) dut_nb (
      .CLK(CLK), .nRST(nRST), .in_valid(in_valid), .in_ready(nb_in_ready),
      .instr_in(instr_in), .npc_in(npc_in), .ctrl_in(ctrl_in), .ext_sel(ext_sel),
      .uses_rt(uses_rt), .dst_in(dst_in), .mem_read_in(mem_read_in), .flush(flush),
      .wb_en(wb_en), .wb_sel(wb_sel), .wb_dat(wb_dat), .wb_jal(wb_jal), .wb_npc(wb_npc),
      .out_valid(nb_out_valid), .out_ready(out_ready), .rdat1_out(nb_rdat1_out),
      .rdat2_out(nb_rdat2_out), .imm_out(nb_imm_out), .npc_out(nb_npc_out),
      .instr_out(nb_instr_out), .ctrl_out(nb_ctrl_out), .dst_out(nb_dst_out),
      .mem_read_out(nb_mem_read_out)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec = nvec + 1;
      if (act !== exp) begin
         nfail = nfail + 1;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] mk(input logic [4:0] s, input logic [4:0] t,
                                      input logic [15:0] im);
      return {6'd0, s, t, im};
   endfunction

   // ---------------- reference model ----------------
   logic [DW-1:0] m_regs [32];
   logic          m_valid, m_mr;
   logic [DW-1:0] m_rd1, m_rd2, m_rd1_nb, m_rd2_nb, m_imm, m_npc;
   logic [31:0]   m_instr;
   logic [CW-1:0] m_ctrl;
   logic [RW-1:0] m_dst;

   logic [4:0]    m_rs, m_rt;
   logic [15:0]   m_im;
   logic [DW-1:0] m_wv, e_rd1, e_rd2, e_rd1_nb, e_rd2_nb, e_imm;
   logic          m_stall, m_can_load, e_in_ready;

   assign m_rs = instr_in[25:21];
   assign m_rt = instr_in[20:16];
   assign m_im = instr_in[15:0];
   assign m_wv = wb_jal ? wb_npc : wb_dat;
   assign e_rd1    = (m_rs == 0) ? '0 : (wb_en && wb_sel == m_rs) ? m_wv : m_regs[m_rs];
   assign e_rd2    = (m_rt == 0) ? '0 : (wb_en && wb_sel == m_rt) ? m_wv : m_regs[m_rt];
   assign e_rd1_nb = (m_rs == 0) ? '0 : m_regs[m_rs];
   assign e_rd2_nb = (m_rt == 0) ? '0 : m_regs[m_rt];
   assign e_imm = (ext_sel == 2'd1) ? {{16{m_im[15]}}, m_im} :
                  (ext_sel == 2'd2) ? (32'(m_im) << 16) : 32'(m_im);
   assign m_stall    = m_valid && m_mr && (m_dst != 0) &&
                       ((m_dst == m_rs) || (uses_rt && m_dst == m_rt));
   assign m_can_load = !m_valid || out_ready;
   assign e_in_ready = m_can_load && (flush || !m_stall);

   always @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         for (int i = 0; i < 32; i++) m_regs[i] <= '0;
         m_valid <= 1'b0; m_mr <= 1'b0; m_rd1 <= '0; m_rd2 <= '0;
         m_rd1_nb <= '0; m_rd2_nb <= '0; m_imm <= '0; m_npc <= '0;
         m_instr <= '0; m_ctrl <= '0; m_dst <= '0;
      end else begin
         if (m_can_load && !flush && !m_stall && in_valid) begin
            m_valid <= 1'b1;
            m_rd1 <= e_rd1; m_rd2 <= e_rd2; m_rd1_nb <= e_rd1_nb; m_rd2_nb <= e_rd2_nb;
            m_imm <= e_imm; m_npc <= npc_in; m_instr <= instr_in; m_ctrl <= ctrl_in;
            m_dst <= dst_in; m_mr <= mem_read_in;
         end else if (flush || m_can_load) begin
            m_valid <= 1'b0;
         end
         if (wb_en && wb_sel != 0) m_regs[wb_sel] <= m_wv;
      end
   end

   // Per-cycle comparison against the model
   always @(negedge CLK) begin
      if (nRST) begin
         check("out_valid", 32'(out_valid), 32'(m_valid));
         check("in_ready", 32'(in_ready), 32'(e_in_ready));
         check("nb_out_valid", 32'(nb_out_valid), 32'(m_valid));
         check("nb_in_ready", 32'(nb_in_ready), 32'(e_in_ready));
         if (m_valid) begin
            check("rdat1_out", rdat1_out, m_rd1);
            check("rdat2_out", rdat2_out, m_rd2);
            check("imm_out", imm_out, m_imm);
            check("npc_out", npc_out, m_npc);
            check("instr_out", instr_out, m_instr);
            check("ctrl_out", 32'(ctrl_out), 32'(m_ctrl));
            check("dst_out", 32'(dst_out), 32'(m_dst));
            check("mem_read_out", 32'(mem_read_out), 32'(m_mr));
            check("nb_rdat1_out", nb_rdat1_out, m_rd1_nb);
            check("nb_rdat2_out", nb_rdat2_out, m_rd2_nb);
         end
      end
   end

   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   // ---------------- directed stimulus ----------------
   initial begin
      nRST = 1'b0; in_valid = 0; flush = 0; uses_rt = 0; mem_read_in = 0; out_ready = 1;
      wb_en = 0; wb_jal = 0; instr_in = '0; npc_in = '0; wb_dat = '0; wb_npc = '0;
      ctrl_in = '0; ext_sel = '0; dst_in = '0; wb_sel = '0;
      cyc(); cyc();
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_rdat1", rdat1_out, 32'd0);
      nRST = 1'b1;

      // write r5 then read it
      wb_en = 1; wb_sel = 5; wb_dat = 32'hDEADBEEF;
      cyc();
      wb_en = 0; in_valid = 1; instr_in = mk(5, 0, 0); ctrl_in = 16'hA5A5; npc_in = 32'h100;
      cyc();
      check("lit_r5_valid", 32'(out_valid), 32'd1);
      check("lit_r5_rdat1", rdat1_out, 32'hDEADBEEF);
      check("lit_r5_ctrl", 32'(ctrl_out), 32'h0000A5A5);

      // same-cycle write/read of r7
      wb_en = 1; wb_sel = 7; wb_dat = 32'h1234; instr_in = mk(7, 0, 0); npc_in = 32'h104;
      cyc();
      check("lit_byp_rdat1", rdat1_out, 32'h1234);
      check("lit_nobyp_rdat1", nb_rdat1_out, 32'h0);
      // r0 write ignored
      wb_sel = 0; wb_dat = 32'hFFFF; instr_in = mk(0, 0, 0);
      cyc();
      check("lit_r0_same", rdat1_out, 32'h0);
      wb_en = 0; uses_rt = 1; instr_in = mk(0, 7, 0);
      cyc();
      check("lit_r0_later", rdat1_out, 32'h0);
      check("lit_r7_rdat2", nb_rdat2_out, 32'h1234);
      uses_rt = 0;

      // immediate modes
      instr_in = mk(0, 0, 16'h8001); ext_sel = 2'd1; cyc();
      check("lit_imm_sext", imm_out, 32'hFFFF8001);
      ext_sel = 2'd0; cyc();
      check("lit_imm_zext", imm_out, 32'h00008001);
      ext_sel = 2'd2; cyc();
      check("lit_imm_lui", imm_out, 32'h80010000);
      ext_sel = 2'd3; cyc();
      check("lit_imm_zext3", imm_out, 32'h00008001);
      ext_sel = 2'd0;

      // jal link writeback
      in_valid = 0; wb_en = 1; wb_sel = 9; wb_jal = 1; wb_npc = 32'hCAFE0000; wb_dat = 32'h1;
      cyc();
      wb_en = 0; wb_jal = 0; in_valid = 1; instr_in = mk(9, 0, 0);
      cyc();
      check("lit_jal_rdat1", rdat1_out, 32'hCAFE0000);

      // load-use stall on rs
      instr_in = mk(0, 0, 0); dst_in = 3; mem_read_in = 1; npc_in = 32'h200;
      cyc();
      instr_in = mk(3, 4, 0); dst_in = 6; mem_read_in = 0; uses_rt = 1; npc_in = 32'h204;
      #1 check("lit_stall_in_ready", 32'(in_ready), 32'd0);
      cyc();
      check("lit_bubble", 32'(out_valid), 32'd0);
      wb_en = 1; wb_sel = 3; wb_dat = 32'h55;
      #1 check("lit_unstall_in_ready", 32'(in_ready), 32'd1);
      cyc();
      check("lit_add_valid", 32'(out_valid), 32'd1);
      check("lit_add_rdat1", rdat1_out, 32'h55);
      wb_en = 0;

      // no stall when rt is not a source
      instr_in = mk(0, 0, 0); dst_in = 3; mem_read_in = 1; uses_rt = 0;
      cyc();
      instr_in = mk(1, 3, 0); dst_in = 6; mem_read_in = 0; npc_in = 32'h300;
      #1 check("lit_nostall_in_ready", 32'(in_ready), 32'd1);
      cyc();
      check("lit_nostall_rdat2", rdat2_out, 32'h55);

      // backpressure for three cycles
      out_ready = 0; instr_in = mk(5, 0, 0); npc_in = 32'h400;
      for (int k = 0; k < 3; k++) begin
         cyc();
         check("lit_bp_valid", 32'(out_valid), 32'd1);
         check("lit_bp_npc", npc_out, 32'h300);
         check("lit_bp_in_ready", 32'(in_ready), 32'd0);
      end
      out_ready = 1;
      cyc();
      check("lit_release_npc", npc_out, 32'h400);
      check("lit_release_rdat1", rdat1_out, 32'hDEADBEEF);

      // flush under backpressure
      out_ready = 0; flush = 1; npc_in = 32'h500;
      #1 check("lit_flush_bp_in_ready", 32'(in_ready), 32'd0);
      cyc();
      check("lit_flush_bp_valid", 32'(out_valid), 32'd0);
      flush = 0; out_ready = 1; npc_in = 32'h600;
      cyc();
      // flush with output valid and incoming valid
      flush = 1; npc_in = 32'h700;
      #1 check("lit_flush_in_ready", 32'(in_ready), 32'd1);
      cyc();
      check("lit_flush_valid", 32'(out_valid), 32'd0);
      flush = 0; in_valid = 0;
      cyc();
      check("lit_flush_dropped", npc_out, 32'h600);

      // reset mid-stream
      in_valid = 1; instr_in = mk(5, 0, 0); npc_in = 32'h800;
      cyc();
      #3 nRST = 1'b0;
      #1 check("lit_midrst_valid", 32'(out_valid), 32'd0);
      check("lit_midrst_npc", npc_out, 32'h0);
      cyc();
      nRST = 1'b1;
      npc_in = 32'h900;
      cyc();
      check("lit_postrst_rdat1", rdat1_out, 32'h0);
      in_valid = 0;
      cyc(); cyc();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
